// File: rtl/shifter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// shifter_pkg -- op encodings and clog2 helper for the barrel shifter
// rev 1.0
// ----------------------------------------------------------------------
package shifter_pkg;

  localparam logic [1:0] SHIFT_OP_SHL  = 2'b00;
  localparam logic [1:0] SHIFT_OP_SHR  = 2'b01;
  localparam logic [1:0] SHIFT_OP_ROTR = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROTL = 2'b11;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shift_stage.sv
`default_nettype none
// ----------------------------------------------------------------------
// barrel_shift_stage -- one 2^STAGE_IDX shift/rotate mux plus stage regs
// rev 1.0
// ----------------------------------------------------------------------
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int STAGE_IDX = 0,
  parameter int SHW       = clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [1:0]       prev_op,
  input  logic [SHW-1:0]   prev_shamt,
  input  logic [TAG_W-1:0] prev_tag,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       op,
  output logic [SHW-1:0]   shamt,
  output logic [TAG_W-1:0] tag
);

  localparam int AMT = 1 << STAGE_IDX;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = prev_data;
    if (prev_shamt[STAGE_IDX]) begin
      case (prev_op)
        SHIFT_OP_SHL:  shifted = prev_data << AMT;
        SHIFT_OP_SHR:  shifted = prev_data >> AMT;
        SHIFT_OP_ROTR: shifted = (prev_data >> AMT) | (prev_data << (WIDTH - AMT));
        default:       shifted = (prev_data << AMT) | (prev_data >> (WIDTH - AMT));
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      op    <= '0;
      shamt <= '0;
      tag   <= '0;
    end else if (advance) begin
      valid <= prev_valid;
      data  <= shifted;
      op    <= prev_op;
      shamt <= prev_shamt;
      tag   <= prev_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------
// pipelined_barrel_shifter -- log2(WIDTH)-stage shift/rotate pipeline
// rev 1.0
// ----------------------------------------------------------------------
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int TAG_W  = 4,
  localparam int SHW    = clog2(WIDTH),
  localparam int STAGES = SHW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Index 0 is the input port; index k+1 is the output of stage k.
  logic [STAGES:0]  valid_s;
  logic [WIDTH-1:0] data_s  [STAGES+1];
  logic [1:0]       op_s    [STAGES+1];
  logic [SHW-1:0]   shamt_s [STAGES+1];
  logic [TAG_W-1:0] tag_s   [STAGES+1];
  logic             advance;

  // Single global enable: stage 0 is only loaded when in_ready is high,
  // so feeding it raw in_valid is equivalent to in_valid && in_ready.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign op_s[0]    = in_op;
  assign shamt_s[0] = in_shamt;
  assign tag_s[0]   = in_tag;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      barrel_shift_stage #(
        .WIDTH     (WIDTH),
        .TAG_W     (TAG_W),
        .STAGE_IDX (k),
        .SHW       (SHW)
      ) u_stage (
        .clock      (clock),
        .reset_n    (reset_n),
        .advance    (advance),
        .prev_valid (valid_s[k]),
        .prev_data  (data_s[k]),
        .prev_op    (op_s[k]),
        .prev_shamt (shamt_s[k]),
        .prev_tag   (tag_s[k]),
        .valid      (valid_s[k+1]),
        .data       (data_s[k+1]),
        .op         (op_s[k+1]),
        .shamt      (shamt_s[k+1]),
        .tag        (tag_s[k+1])
      );
    end
  endgenerate

  assign out_valid = valid_s[STAGES];
  assign out_data  = data_s[STAGES];
  assign out_tag   = tag_s[STAGES];

  logic unused_tail;
  assign unused_tail = ^{op_s[STAGES], shamt_s[STAGES]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_pipelined_barrel_shifter -- scoreboard bench, WIDTH 32 and WIDTH 8
// rev 1.0
// ----------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

  localparam int TW = 4;

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0]   a_in_data, a_out_data;
  logic [4:0]    a_in_shamt;
  logic [1:0]    a_in_op;
  logic [TW-1:0] a_in_tag, a_out_tag;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]    b_in_data, b_out_data;
  logic [2:0]    b_in_shamt;
  logic [1:0]    b_in_op;
  logic [TW-1:0] b_in_tag, b_out_tag;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   tests = 0;
  int   fails = 0;

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(TW)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag)
  );

  pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(TW)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  // Reference: shift/rotate of a w-bit value via 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                        input logic [1:0] op, input int w);
    logic [63:0] x, m, r;
    m = (64'd1 << w) - 64'd1;
    x = {32'd0, d} & m;
    case (op)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = (x >> s) | (x << (w - s));
      default: r = (x << s) | (x >> (w - s));
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_in_tag = '0;
    a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0;
    b_out_ready = 1'b1;
    next_cycle();
    next_cycle();
    tests++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'd0 || a_out_tag !== '0 || a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset32: valid=%b data=%h tag=%h ready=%b, required 0/0/0/1",
               a_out_valid, a_out_data, a_out_tag, a_in_ready);
    end
    tests++;
    if (b_out_valid !== 1'b0 || b_out_data !== 8'd0 || b_out_tag !== '0 || b_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset8: valid=%b data=%h tag=%h ready=%b, required 0/0/0/1",
               b_out_valid, b_out_data, b_out_tag, b_in_ready);
    end
    reset_n = 1'b1;
    next_cycle();
  endtask

  // Fixed vectors with hand-computed results; also checks 5-cycle latency.
  task automatic test_directed();
    logic [31:0]   vd [8] = '{32'h80000001, 32'h80000000, 32'h12345678, 32'h12345678,
                              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    logic [4:0]    vs [8] = '{5'd1, 5'd31, 5'd4, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [1:0]    vo [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0]   vx [8] = '{32'h00000002, 32'h00000001, 32'h81234567, 32'h34567812,
                              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    exp_t e;
    int   k = 0;
    int   got = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 40 && got < 8; i++) begin
      a_in_valid = (k < 8);
      if (k < 8) begin
        a_in_data = vd[k]; a_in_shamt = vs[k]; a_in_op = vo[k]; a_in_tag = TW'(k + 5);
      end
      #1;
      if (a_in_valid && a_in_ready) begin
        e.data = vx[k]; e.tag = TW'(k + 5); e.cyc = cyc;
        sb_a.push_back(e);
        k++;
      end
      if (a_out_valid && a_out_ready) begin
        got++;
        tests++;
        if (sb_a.size() == 0) begin
          fails++;
          $display("FAIL directed_extra: data=%h tag=%h, required no output", a_out_data, a_out_tag);
        end else begin
          e = sb_a.pop_front();
          if (a_out_data !== e.data || a_out_tag !== e.tag || cyc - e.cyc != 5) begin
            fails++;
            $display("FAIL directed: data=%h tag=%h latency=%0d, required data=%h tag=%h latency=5",
                     a_out_data, a_out_tag, cyc - e.cyc, e.data, e.tag);
          end
        end
      end
      next_cycle();
    end
    a_in_valid = 1'b0;
    tests++;
    if (got != 8 || sb_a.size() != 0) begin
      fails++;
      $display("FAIL directed_count: got %0d results, required 8", got);
    end
  endtask

  task automatic test_back_to_back();
    exp_t          e;
    logic [31:0]   held_d;
    logic [TW-1:0] held_t;
    int            k = 0;
    int            got = 0;
    for (int i = 0; i < 60 && got < 8; i++) begin
      a_out_ready = !(i >= 7 && i <= 9);
      a_in_valid  = (k < 8);
      if (k < 8) begin
        a_in_data  = 32'($urandom);
        a_in_shamt = 5'($urandom_range(0, 31));
        a_in_op    = 2'($urandom_range(0, 3));
        a_in_tag   = TW'(k);
      end
      #1;
      if (!a_out_ready && a_out_valid) begin
        tests++;
        if (a_in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_ready: in_ready=%b, required 0", a_in_ready);
        end
        if (i >= 8) begin
          tests++;
          if (a_out_data !== held_d || a_out_tag !== held_t) begin
            fails++;
            $display("FAIL stall_hold: data=%h tag=%h, required data=%h tag=%h",
                     a_out_data, a_out_tag, held_d, held_t);
          end
        end
      end
      held_d = a_out_data;
      held_t = a_out_tag;
      if (a_in_valid && a_in_ready) begin
        e.data = model(a_in_data, int'(a_in_shamt), a_in_op, 32);
        e.tag = a_in_tag; e.cyc = cyc;
        sb_a.push_back(e);
        k++;
      end
      if (a_out_valid && a_out_ready) begin
        tests++;
        if (sb_a.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra: data=%h tag=%h, required no output", a_out_data, a_out_tag);
        end else begin
          e = sb_a.pop_front();
          if (a_out_data !== e.data || a_out_tag !== e.tag || a_out_tag !== TW'(got)) begin
            fails++;
            $display("FAIL b2b: data=%h tag=%h, required data=%h tag=%h",
                     a_out_data, a_out_tag, e.data, TW'(got));
          end
        end
        got++;
      end
      next_cycle();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tests++;
    if (got != 8 || sb_a.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: got %0d results, required 8", got);
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_data = 32'hA5A50000 + 32'(i);
      a_in_shamt = 5'(i + 1); a_in_op = 2'(i); a_in_tag = TW'(i + 9);
      next_cycle();
    end
    a_in_valid = 1'b0;
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    tests++;
    if (a_out_valid !== 1'b0 || a_out_data !== 32'd0 || a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset: valid=%b data=%h ready=%b, required 0/0/1",
               a_out_valid, a_out_data, a_in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      if (a_out_valid) seen++;
      next_cycle();
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midreset_flush: %0d outputs after reset, required 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   ka = 0;
    int   kb = 0;
    logic drive;
    for (int i = 0; i < 3000; i++) begin
      drive = (ka < 160 || kb < 64);
      if (!drive && sb_a.size() == 0 && sb_b.size() == 0) break;
      a_in_valid = drive && ($urandom_range(0, 3) != 0);
      a_in_data = 32'($urandom); a_in_shamt = 5'(ka % 32); a_in_op = 2'((ka / 32) % 4);
      a_in_tag = TW'($urandom); a_out_ready = !drive || ($urandom_range(0, 2) != 0);
      b_in_valid = drive && ($urandom_range(0, 3) != 0);
      b_in_data = 8'($urandom); b_in_shamt = 3'(kb % 8); b_in_op = 2'((kb / 8) % 4);
      b_in_tag = TW'($urandom); b_out_ready = !drive || ($urandom_range(0, 1) != 0);
      #1;
      if (a_in_valid && a_in_ready) begin
        e.data = model(a_in_data, int'(a_in_shamt), a_in_op, 32);
        e.tag = a_in_tag; e.cyc = cyc;
        sb_a.push_back(e);
        ka++;
      end
      if (b_in_valid && b_in_ready) begin
        e.data = model({24'd0, b_in_data}, int'(b_in_shamt), b_in_op, 8);
        e.tag = b_in_tag; e.cyc = cyc;
        sb_b.push_back(e);
        kb++;
      end
      if (a_out_valid && a_out_ready) begin
        tests++;
        if (sb_a.size() == 0) begin
          fails++;
          $display("FAIL rand32_extra: data=%h, required no output", a_out_data);
        end else begin
          e = sb_a.pop_front();
          if (a_out_data !== e.data || a_out_tag !== e.tag) begin
            fails++;
            $display("FAIL rand32: data=%h tag=%h, required data=%h tag=%h",
                     a_out_data, a_out_tag, e.data, e.tag);
          end
        end
      end
      if (b_out_valid && b_out_ready) begin
        tests++;
        if (sb_b.size() == 0) begin
          fails++;
          $display("FAIL rand8_extra: data=%h, required no output", b_out_data);
        end else begin
          e = sb_b.pop_front();
          if (b_out_data !== e.data[7:0] || b_out_tag !== e.tag) begin
            fails++;
            $display("FAIL rand8: data=%h tag=%h, required data=%h tag=%h",
                     b_out_data, b_out_tag, e.data[7:0], e.tag);
          end
        end
      end
      next_cycle();
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    tests++;
    if (sb_a.size() != 0 || sb_b.size() != 0 || ka < 160 || kb < 64) begin
      fails++;
      $display("FAIL rand_drain: pending32=%0d pending8=%0d sent32=%0d sent8=%0d, required 0/0/>=160/>=64",
               sb_a.size(), sb_b.size(), ka, kb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter/rotator for the SHA-256 datapath and general FPGA use, generalising the team's fixed 32-bit one-bit left shifter. It accepts one operand per cycle with a per-operand shift amount and mode: logical left, logical right, rotate right or rotate left. Operands pass through log2(WIDTH) registered stages under a valid/ready handshake with backpressure. An opaque tag is carried alongside each operand so the message-schedule and compression logic can match results to requests.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 2
- TAG_W, 4, width of the pass-through tag; ≥ 1
- Derived (localparam, not overridable): SHW = clog2(WIDTH); STAGES = SHW
- clock  in  1  rising-edge clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block accepts the operand this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, 0..WIDTH-1
- in_op  in  2  mode: 00 SHL, 01 SHR, 10 ROTR, 11 ROTL
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  shifted/rotated result
- out_tag  out  TAG_W  tag of the result

## Operation
- Transfer on the input side occurs when in_valid && in_ready. Transfer on the output side occurs when out_valid && out_ready.
- Stage k (k = 0..STAGES-1) takes word w, op and shamt from stage k-1 (or from the inputs for k = 0):
  - If shamt[k] = 0, it passes w unchanged.
  - Otherwise it shifts or rotates w by 2^k:
    - SHL: left shift, zero fill.
    - SHR: right shift, zero fill.
    - ROTR: bits leaving the LSB re-enter at the MSB.
    - ROTL: bits leaving the MSB re-enter at the LSB.
- Each stage registers valid, w, op, shamt and tag. The last stage drives out_valid, out_data and out_tag.
- Net result: SHL = in_data << shamt; SHR = in_data >> shamt; ROTR/ROTL = rotation by shamt. shamt = 0 always passes in_data through unchanged.
- No arithmetic right shift. No shift by ≥ WIDTH; the shamt width makes it unrepresentable.
- Global stall: advance = !(out_valid && !out_ready).
  - When advance = 1, every stage register loads from its predecessor. Stage 0 loads in_valid && in_ready.
  - When advance = 0, all stage registers hold.
- in_ready = advance. It is combinational from out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- Bubbles are not collapsed: an empty stage still waits for a global stall to release.
- The tag is never inspected or modified.

## Timing
- Reset (reset_n = 0 at a rising edge) clears all stage valids, data, op, shamt and tag registers to 0. After that edge:
  - out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1.
- Reset has priority over advance. Asserting reset mid-stream discards every in-flight operand; none is emitted afterward.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance when unstalled. For WIDTH = 32 that is 5 cycles.
- Throughput: one operand per cycle while out_ready = 1.
- When out_valid = 1 and out_ready = 0:
  - out_data and out_tag are held stable.
  - in_ready = 0 in the same cycle.
  - Any in_valid presented that cycle is not accepted.
- Simultaneous input and output transfer in the same cycle is the normal steady state. Ordering is strictly FIFO.
- out_ready may toggle freely. Results are never lost or duplicated.

## Structure
- Package shifter_pkg: op encodings SHIFT_OP_SHL = 2'b00, SHIFT_OP_SHR = 2'b01, SHIFT_OP_ROTR = 2'b10, SHIFT_OP_ROTL = 2'b11. Also a clog2 helper function.
- Sub-module barrel_shift_stage is parametrised by WIDTH, TAG_W and STAGE_IDX. It contains the combinational 2^STAGE_IDX shift/rotate mux plus the enable-gated stage registers.
- The top level generates STAGES instances and the advance/in_ready logic.

## Test plan
- WIDTH = 32, unstalled:
  - SHL by 1 of 0x80000001 gives 0x00000002.
  - SHR by 31 of 0x80000000 gives 0x00000001.
  - ROTR by 4 of 0x12345678 gives 0x81234567.
  - ROTL by 8 of 0x12345678 gives 0x34567812.
  - Each result appears exactly 5 cycles after acceptance.
- shamt = 0 in every op on 0xDEADBEEF returns 0xDEADBEEF with tag preserved.
- Stream 8 back-to-back operands tagged 0..7, with out_ready low for 3 cycles mid-stream:
  - out_data and out_tag are held while stalled.
  - in_ready = 0 while stalled.
  - All 8 results arrive in order with no loss or duplication.
- With 3 operands in flight, drive reset_n low for 1 cycle:
  - The next cycle shows out_valid = 0, out_data = 0 and in_ready = 1.
  - None of the 3 operands is ever emitted.
- Random sweep of all ops, all shamt values, random data and random out_ready at WIDTH = 32 and WIDTH = 8 (latency 3). Results must match a scoreboard model.
